// File: rtl/mem_responder.sv
// mem_responder: 4096 x 12-bit word memory behind a simple CPU
// request/response handshake, with a front-panel deposit port.
// A request is captured in IDLE. It waits WAIT_STATES cycles and then
// completes with a single-cycle mem_valid pulse in RESP.
module mem_responder #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [11:0] addr,
  input  logic [11:0] wdata,
  output logic [11:0] rdata,
  output logic        mem_valid,
  output logic        mem_error,
  input  logic        ld_en,
  input  logic [11:0] ld_addr,
  input  logic [11:0] ld_data,
  output logic        ld_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic [11:0] addr_q, wdata_q;
  logic        rd_q, wr_q;

  logic        accept, enter_resp, ld_hit;
  logic [11:0] acc_addr, acc_wdata;
  logic        acc_rd, acc_wr;
  logic        wr_en;
  logic [11:0] wr_addr, wr_data;

  logic [11:0] mem [4096];
  logic [11:0] rd_word;
  logic        resp_read;

  // Next-state logic and the single-cycle strobes derived from it
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case leaves one unassigned and infers a latch.
    next_state = state;
    accept     = 1'b0;
    enter_resp = 1'b0;
    ld_hit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            next_state = RESP;
            enter_resp = 1'b1;
          end else begin
            next_state = WAIT;
          end
        end else if (ld_en) begin
          ld_hit = 1'b1;
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          next_state = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Transaction fields: the live inputs on a zero-wait capture, else the latched copy
  always_comb begin
    acc_addr  = (state == IDLE) ? addr      : addr_q;
    acc_wdata = (state == IDLE) ? wdata     : wdata_q;
    acc_rd    = (state == IDLE) ? mem_read  : rd_q;
    acc_wr    = (state == IDLE) ? mem_write : wr_q;
  end

  // Single memory write port shared by CPU writes and deposits
  always_comb begin
    // The memory has no reset of its own. While reset_n is low the FSM
    // sits in IDLE, so both write sources are gated here to keep a held
    // request or deposit from modifying memory during reset.
    wr_en   = 1'b0;
    wr_addr = ld_addr;
    wr_data = ld_data;
    if (reset_n && enter_resp && acc_wr && !acc_rd) begin
      wr_en   = 1'b1;
      wr_addr = acc_addr;
      wr_data = acc_wdata;
    end else if (reset_n && ld_hit) begin
      wr_en = 1'b1;
    end
  end

  // Storage array and read port; the read samples on RESP entry
  always_ff @(posedge clk) begin
    // NOTE: the memory array is deliberately left out of reset. Contents must survive reset, and a resettable 4096-word array cannot map onto RAM.
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (enter_resp) begin
      rd_word <= mem[acc_addr];
    end
  end

  // State, wait counter, request latches and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      mem_valid <= 1'b0;
      mem_error <= 1'b0;
      resp_read <= 1'b0;
      ld_ack    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments give every register here its pre-edge value on the right-hand side, whatever order the statements are in.
      state <= next_state;
      if (accept) begin
        cnt     <= WAIT_INIT;
        addr_q  <= addr;
        wdata_q <= wdata;
        rd_q    <= mem_read;
        wr_q    <= mem_write;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      mem_valid <= enter_resp;
      mem_error <= enter_resp && acc_rd && acc_wr;
      resp_read <= enter_resp && acc_rd && !acc_wr;
      ld_ack    <= ld_hit;
    end
  end

  // Read data is only driven during a legal read response
  assign rdata = resp_read ? rd_word : 12'd0;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three instances (WAIT_STATES = 0, 1, 3) share one
// set of inputs. Each instance is compared every cycle against a
// transaction-scheduling reference model. On top of that come a table
// of single transactions and a few directed multi-cycle sequences.
module tb_mem_responder;

  localparam int N_DUT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_read, mem_write, ld_en;
  logic [11:0] addr, wdata, ld_addr, ld_data;

  logic [11:0] rdata_o [N_DUT];
  logic        valid_o [N_DUT];
  logic        error_o [N_DUT];
  logic        ack_o   [N_DUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    mem_responder #(.WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3))) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata_o[g]),
      .mem_valid (valid_o[g]),
      .mem_error (error_o[g]),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .ld_ack    (ack_o[g])
    );
  end

  function automatic int ws_of(int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  // Reference model: a request is scheduled to complete at a given cycle,
  // and the responder becomes free again two cycles after that.
  logic [11:0] mdl_mem [N_DUT][4096];
  bit          pend    [N_DUT];
  bit          p_rd    [N_DUT];
  bit          p_wr    [N_DUT];
  logic [11:0] p_addr  [N_DUT];
  logic [11:0] p_wdata [N_DUT];
  int          resp_at [N_DUT];
  int          free_at [N_DUT];
  bit          e_valid [N_DUT];
  bit          e_err   [N_DUT];
  bit          e_ack   [N_DUT];
  bit          e_rd    [N_DUT];
  logic [11:0] e_rdata [N_DUT];
  int          cyc = 0;

  // Observations collected over a transaction window
  int          vcount   [N_DUT];
  int          acks     [N_DUT];
  int          voff     [N_DUT];
  logic [11:0] first_rd [N_DUT];
  logic [11:0] last_rd  [N_DUT];
  logic        last_err [N_DUT];
  int          obs_base;

  task automatic model_edge(int d);
    e_valid[d] = 1'b0;
    e_err[d]   = 1'b0;
    e_ack[d]   = 1'b0;
    e_rd[d]    = 1'b0;
    e_rdata[d] = 12'd0;
    if (!reset_n) begin
      pend[d]    = 1'b0;
      free_at[d] = 0;
      return;
    end
    if (!pend[d] && cyc >= free_at[d]) begin
      if (mem_read || mem_write) begin
        pend[d]    = 1'b1;
        p_rd[d]    = mem_read;
        p_wr[d]    = mem_write;
        p_addr[d]  = addr;
        p_wdata[d] = wdata;
        resp_at[d] = cyc + ws_of(d);
        free_at[d] = cyc + ws_of(d) + 2;
      end else if (ld_en) begin
        mdl_mem[d][ld_addr] = ld_data;
        e_ack[d] = 1'b1;
      end
    end
    if (pend[d] && cyc == resp_at[d]) begin
      pend[d]    = 1'b0;
      e_valid[d] = 1'b1;
      if (p_rd[d] && p_wr[d]) begin
        e_err[d] = 1'b1;
      end else if (p_wr[d]) begin
        mdl_mem[d][p_addr[d]] = p_wdata[d];
      end else begin
        e_rd[d]    = 1'b1;
        e_rdata[d] = mdl_mem[d][p_addr[d]];
      end
    end
  endtask

  task automatic compare_outputs(int d, string tag);
    logic [11:0] act_rd;
    // rdata carries no meaning during a write response, so it is not compared there
    act_rd = (e_valid[d] && !e_rd[d] && !e_err[d]) ? 12'd0 : rdata_o[d];
    check($sformatf("dut%0d %s cyc%0d", d, tag, cyc),
          {1'b0, valid_o[d], error_o[d], ack_o[d], act_rd},
          {1'b0, e_valid[d], e_err[d], e_ack[d], e_rdata[d]});
    if (valid_o[d] === 1'b1) begin
      vcount[d]++;
      if (vcount[d] == 1) begin
        first_rd[d] = rdata_o[d];
        voff[d]     = cyc - obs_base;
      end
      last_rd[d]  = rdata_o[d];
      last_err[d] = error_o[d];
    end
    if (ack_o[d] === 1'b1) acks[d]++;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    for (int d = 0; d < N_DUT; d++) model_edge(d);
    #1;
    for (int d = 0; d < N_DUT; d++) compare_outputs(d, "out");
  endtask

  task automatic clear_obs();
    for (int d = 0; d < N_DUT; d++) begin
      vcount[d]   = 0;
      acks[d]     = 0;
      voff[d]     = -1;
      first_rd[d] = 12'd0;
      last_rd[d]  = 12'd0;
      last_err[d] = 1'b0;
    end
    obs_base = cyc + 1;
  endtask

  task automatic drive(input bit rd, input bit wr, input bit ld,
                       input logic [11:0] a, input logic [11:0] wd,
                       input logic [11:0] la, input logic [11:0] ldd);
    mem_read  = rd;
    mem_write = wr;
    ld_en     = ld;
    addr      = a;
    wdata     = wd;
    ld_addr   = la;
    ld_data   = ldd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 12'd0);
  endtask

  // Asynchronous reset asserted mid-cycle: outputs must drop before any edge
  task automatic mid_reset();
    #2 reset_n = 1'b0;
    #1;
    for (int d = 0; d < N_DUT; d++) begin
      pend[d]    = 1'b0;
      free_at[d] = 0;
      e_valid[d] = 1'b0;
      e_err[d]   = 1'b0;
      e_ack[d]   = 1'b0;
      e_rd[d]    = 1'b0;
      e_rdata[d] = 12'd0;
      compare_outputs(d, "async_reset");
    end
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    bit          ld;
    logic [11:0] addr;
    logic [11:0] wdata;
    logic [11:0] ld_addr;
    logic [11:0] ld_data;
    bit          exp_valid;
    bit          exp_err;
    bit          exp_ack;
    bit          chk_rdata;
    logic [11:0] exp_rdata;
  } vec_t;

  vec_t vecs [15];

  initial begin
    vecs[0]  = '{0, 0, 1, 12'o0000, 12'o0000, 12'o0200, 12'o7402, 0, 0, 1, 0, 12'o0000};
    vecs[1]  = '{1, 0, 0, 12'o0200, 12'o0000, 12'o0000, 12'o0000, 1, 0, 0, 1, 12'o7402};
    vecs[2]  = '{0, 1, 0, 12'o0017, 12'o1234, 12'o0000, 12'o0000, 1, 0, 0, 0, 12'o0000};
    vecs[3]  = '{1, 0, 0, 12'o0017, 12'o0000, 12'o0000, 12'o0000, 1, 0, 0, 1, 12'o1234};
    vecs[4]  = '{0, 0, 1, 12'o0000, 12'o0000, 12'o0005, 12'o0777, 0, 0, 1, 0, 12'o0000};
    vecs[5]  = '{1, 1, 0, 12'o0005, 12'o1111, 12'o0000, 12'o0000, 1, 1, 0, 1, 12'o0000};
    vecs[6]  = '{1, 0, 0, 12'o0005, 12'o0000, 12'o0000, 12'o0000, 1, 0, 0, 1, 12'o0777};
    vecs[7]  = '{0, 0, 1, 12'o0000, 12'o0000, 12'o0100, 12'o2525, 0, 0, 1, 0, 12'o0000};
    vecs[8]  = '{0, 0, 1, 12'o0000, 12'o0000, 12'o0101, 12'o4343, 0, 0, 1, 0, 12'o0000};
    vecs[9]  = '{1, 0, 1, 12'o0100, 12'o0000, 12'o0101, 12'o7777, 1, 0, 0, 1, 12'o2525};
    vecs[10] = '{1, 0, 0, 12'o0101, 12'o0000, 12'o0000, 12'o0000, 1, 0, 0, 1, 12'o4343};
    vecs[11] = '{0, 0, 1, 12'o0000, 12'o0000, 12'o0000, 12'o6666, 0, 0, 1, 0, 12'o0000};
    vecs[12] = '{0, 1, 0, 12'o7777, 12'o0001, 12'o0000, 12'o0000, 1, 0, 0, 0, 12'o0000};
    vecs[13] = '{1, 0, 0, 12'o0000, 12'o0000, 12'o0000, 12'o0000, 1, 0, 0, 1, 12'o6666};
    vecs[14] = '{1, 0, 0, 12'o7777, 12'o0000, 12'o0000, 12'o0000, 1, 0, 0, 1, 12'o0001};

    reset_n = 1'b0;
    idle();
    for (int d = 0; d < N_DUT; d++) begin
      pend[d]    = 1'b0;
      free_at[d] = 0;
    end
    clear_obs();
    repeat (2) step();
    reset_n = 1'b1;

    // Preload every location through the deposit port
    for (int i = 0; i < 4096; i++) begin
      drive(1'b0, 1'b0, 1'b1, 12'd0, 12'd0, 12'(i), 12'($urandom));
      step();
    end
    idle();
    step();

    // Single-transaction table
    for (int v = 0; v < 15; v++) begin
      clear_obs();
      drive(vecs[v].rd, vecs[v].wr, vecs[v].ld, vecs[v].addr, vecs[v].wdata,
            vecs[v].ld_addr, vecs[v].ld_data);
      step();
      idle();
      repeat (6) step();
      for (int d = 0; d < N_DUT; d++) begin
        check($sformatf("vec%0d dut%0d valid_count", v, d), 16'(vcount[d]), 16'(vecs[v].exp_valid));
        check($sformatf("vec%0d dut%0d ack_count", v, d), 16'(acks[d]), 16'(vecs[v].exp_ack));
        if (vecs[v].exp_valid) begin
          check($sformatf("vec%0d dut%0d latency", v, d), 16'(voff[d]), 16'(ws_of(d)));
          check($sformatf("vec%0d dut%0d error", v, d), 16'(last_err[d]), 16'(vecs[v].exp_err));
          if (vecs[v].chk_rdata)
            check($sformatf("vec%0d dut%0d rdata", v, d), 16'(last_rd[d]), 16'(vecs[v].exp_rdata));
        end
      end
    end

    // Write held one extra cycle, then switched to a read of the same word
    drive(1'b0, 1'b0, 1'b1, 12'd0, 12'd0, 12'o0027, 12'o0000);
    step();
    idle();
    step();
    clear_obs();
    drive(1'b0, 1'b1, 1'b0, 12'o0027, 12'o1234, 12'd0, 12'd0);
    step();
    step();
    drive(1'b1, 1'b0, 1'b0, 12'o0027, 12'd0, 12'd0, 12'd0);
    step();
    idle();
    repeat (6) step();
    check("b2b_wr_rd ws0 pulses", 16'(vcount[0]), 16'd2);
    check("b2b_wr_rd ws0 rdata", 16'(last_rd[0]), 16'o1234);

    // Read held continuously across an address change
    clear_obs();
    drive(1'b1, 1'b0, 1'b0, 12'o0100, 12'd0, 12'd0, 12'd0);
    repeat (3) step();
    drive(1'b1, 1'b0, 1'b0, 12'o0101, 12'd0, 12'd0, 12'd0);
    repeat (3) step();
    idle();
    repeat (6) step();
    check("held_read ws1 pulses", 16'(vcount[1]), 16'd2);
    check("held_read ws1 first rdata", 16'(first_rd[1]), 16'o2525);
    check("held_read ws1 second rdata", 16'(last_rd[1]), 16'o4343);

    // Reset in the second WAIT cycle of the three-wait-state instance
    drive(1'b0, 1'b0, 1'b1, 12'd0, 12'd0, 12'o4000, 12'o1357);
    step();
    idle();
    step();
    clear_obs();
    drive(1'b0, 1'b1, 1'b0, 12'o4000, 12'o5555, 12'd0, 12'd0);
    step();
    idle();
    step();
    mid_reset();
    repeat (2) step();
    reset_n = 1'b1;
    repeat (5) step();
    check("reset_abort ws3 no valid", 16'(vcount[2]), 16'd0);
    clear_obs();
    drive(1'b1, 1'b0, 1'b0, 12'o4000, 12'd0, 12'd0, 12'd0);
    step();
    idle();
    repeat (6) step();
    check("reset_abort ws3 old word", 16'(last_rd[2]), 16'o1357);
    check("reset_abort ws0 committed", 16'(last_rd[0]), 16'o5555);

    // Randomized traffic, including requests that change or drop mid-wait
    for (int i = 0; i < 1000; i++) begin
      int          kind;
      logic [11:0] a;
      kind = int'($urandom_range(0, 9));
      a    = ($urandom_range(0, 1) == 0) ? 12'(12'o0300 + $urandom_range(0, 3)) : 12'($urandom);
      drive((kind <= 2) || (kind == 5) || (kind == 8),
            (kind == 3) || (kind == 4) || (kind == 5),
            (kind == 6) || (kind == 7) || (kind == 8),
            a, 12'($urandom),
            ($urandom_range(0, 1) == 0) ? a : 12'($urandom), 12'($urandom));
      step();
    end
    idle();
    repeat (8) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
